sa_step_controller: RTL and testbench

Sequencer for the 3x3 systolic-array datapath. On a start request it clears the accumulators and steps a 4-bit schedule index cnt through 0..NUM_STEPS-1. The index drives the parent's SA enable decoder, which turns it into 3-bit PE-row enables. The block then waits out the array pipeline latency and presents a result-valid handshake to the downstream consumer. It sits in the SA top level, between the host/control FSM and the PE array.

---
 rtl/sa_ctrl_pkg.sv | 22 ++
 rtl/sa_step_controller.sv | 126 ++++++++++++
 tb/tb_sa_step_controller.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sa_ctrl_pkg.sv
// Shared definitions for the systolic-array step controller, its enable
// decoder and the SA top level.
package sa_ctrl_pkg;

    // Schedule geometry of the 3x3 array.
    localparam int SA_CNT_W        = 4;
    localparam int SA_NUM_STEPS    = 9;
    localparam int SA_DRAIN_CYCLES = 2;

    // Width of the drain counter; covers the full 1..15 drain range.
    localparam int SA_DRAIN_W      = 4;

    // Controller state encoding.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } sa_state_e;

endpackage : sa_ctrl_pkg

// File: rtl/sa_step_controller.sv
// Step sequencer for the 3x3 systolic array: clears the accumulators, walks
// the schedule index through 0..NUM_STEPS-1 under in_valid flow control,
// waits out the pipeline drain and offers the result with a valid/ready
// handshake. The enable decoder that consumes cnt lives in the parent.
module sa_step_controller
    import sa_ctrl_pkg::*;
#(
    parameter int CNT_W        = SA_CNT_W,
    parameter int NUM_STEPS    = SA_NUM_STEPS,
    parameter int DRAIN_CYCLES = SA_DRAIN_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt,
    output logic             step_en,
    output logic             acc_clr,
    output logic             busy,
    output logic             out_valid,
    output logic             done
);

    // Final schedule index and final drain count, pre-sized for comparison.
    localparam logic [CNT_W-1:0]      LAST_STEP  = CNT_W'(NUM_STEPS - 1);
    localparam logic [SA_DRAIN_W-1:0] DRAIN_LAST = SA_DRAIN_W'(DRAIN_CYCLES - 1);

    sa_state_e               state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [SA_DRAIN_W-1:0]   drain_q;
    logic                    acc_clr_q;
    logic                    busy_q;
    logic                    out_valid_q;
    logic                    done_q;

    // Sequencer state, schedule/drain counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            drain_q     <= '0;
            acc_clr_q   <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // done is a single-cycle pulse; it drops in this cycle
                    // even when a back-to-back start is accepted.
                    done_q <= 1'b0;
                    cnt_q  <= '0;
                    if (start) begin
                        state_q   <= CLEAR;
                        acc_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q   <= IDLE;
                        acc_clr_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                CLEAR: begin
                    acc_clr_q <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= RUN;
                end
                RUN: begin
                    // A low in_valid stalls everything; only a high sample
                    // advances the schedule, including on the last step.
                    if (in_valid) begin
                        if (cnt_q == LAST_STEP) begin
                            state_q <= DRAIN;
                            drain_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q;
                    end
                end
                DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q     <= OUT;
                        out_valid_q <= 1'b1;
                    end else begin
                        drain_q <= drain_q + SA_DRAIN_W'(1);
                    end
                end
                OUT: begin
                    // Result stays offered until the consumer takes it.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        cnt_q       <= '0;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encodings recover to a clean idle.
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    drain_q     <= '0;
                    acc_clr_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    // The advance strobe must follow in_valid in the same cycle, so it is
    // the one combinational output.
    assign step_en   = (state_q == RUN) & in_valid;
    assign cnt       = cnt_q;
    assign acc_clr   = acc_clr_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule : sa_step_controller

// File: tb/tb_sa_step_controller.sv
// Directed, table-driven bench for sa_step_controller: default geometry plus
// a NUM_STEPS=1 / DRAIN_CYCLES=1 instance.
module tb_sa_step_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start2;
    logic       in_valid;
    logic       out_ready;

    logic [3:0] cnt;
    logic       step_en, acc_clr, busy, out_valid, done;
    logic [3:0] cnt2;
    logic       step_en2, acc_clr2, busy2, out_valid2, done2;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic       st;
        logic       iv;
        logic       ordy;
        logic [3:0] cnt;
        logic       se;
        logic       clr;
        logic       bz;
        logic       ov;
        logic       dn;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    sa_step_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .out_ready(out_ready), .cnt(cnt), .step_en(step_en), .acc_clr(acc_clr),
        .busy(busy), .out_valid(out_valid), .done(done)
    );

    sa_step_controller #(.CNT_W(4), .NUM_STEPS(1), .DRAIN_CYCLES(1)) dut_min (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid),
        .out_ready(out_ready), .cnt(cnt2), .step_en(step_en2), .acc_clr(acc_clr2),
        .busy(busy2), .out_valid(out_valid2), .done(done2)
    );

    task automatic check(input string name, input int idx, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: actual {cnt,step_en,acc_clr,busy,out_valid,done}=%0d,%b,%b,%b,%b,%b required %0d,%b,%b,%b,%b,%b",
                     name, idx, got[8:5], got[4], got[3], got[2], got[1], got[0],
                     exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic v(input logic st, input logic iv, input logic ordy, input int c,
                     input logic se, input logic clr, input logic bz, input logic ov, input logic dn);
        vec_t e;
        e.st = st; e.iv = iv; e.ordy = ordy; e.cnt = 4'(c);
        e.se = se; e.clr = clr; e.bz = bz; e.ov = ov; e.dn = dn;
        tbl.push_back(e);
    endtask

    // Each entry: inputs for one cycle and the outputs expected in that cycle.
    task automatic run_table(input string name, input bit sel);
        logic [8:0] got;
        logic [8:0] exp;
        for (int i = 0; i < tbl.size(); i++) begin
            if (sel) start2 = tbl[i].st;
            else     start  = tbl[i].st;
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            #1;
            got = sel ? {cnt2, step_en2, acc_clr2, busy2, out_valid2, done2}
                      : {cnt, step_en, acc_clr, busy, out_valid, done};
            exp = {tbl[i].cnt, tbl[i].se, tbl[i].clr, tbl[i].bz, tbl[i].ov, tbl[i].dn};
            check(name, i, got, exp);
            @(posedge clk); #1;
        end
        tbl.delete();
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic fill_basic();
        v(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) v(1'b0, 1'b1, 1'b1, k, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        v(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        v(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #12;
        check("in_reset", 0, {cnt, step_en, acc_clr, busy, out_valid, done}, 9'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal run: out_valid at cycle 13, done at cycle 14.
        fill_basic();
        run_table("basic", 1'b0);

        // Three stall cycles at cnt=4 push everything out by three cycles.
        v(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) v(1'b0, 1'b1, 1'b1, k, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) v(1'b0, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 4; k < 9; k++) v(1'b0, 1'b1, 1'b1, k, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        v(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        v(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_table("stall", 1'b0);

        // Stall on the final step, early out_ready, then 5 cycles of backpressure.
        v(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) v(1'b0, 1'b1, 1'b1, k, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        v(1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) v(1'b0, 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        v(1'b0, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        v(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        v(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_table("backpressure", 1'b0);

        // start held high: ignored while busy, back-to-back restart after done.
        v(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        v(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) v(1'b1, 1'b1, 1'b1, k, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        v(1'b1, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        v(1'b1, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        v(1'b1, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        v(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        v(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) v(1'b0, 1'b1, 1'b1, k, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_table("b2b", 1'b0);

        // Second operation is now at cnt=5; reset must clear it without a clock edge.
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("pre_reset", 0, {cnt, step_en, acc_clr, busy, out_valid, done}, {4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 0, {cnt, step_en, acc_clr, busy, out_valid, done}, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean full sequence after the mid-operation reset.
        fill_basic();
        run_table("after_reset", 1'b0);

        // Minimal geometry: single step, one drain cycle.
        v(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        v(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        v(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_table("min_geom", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sa_step_controller
